// File: rtl/freq_meter_if.sv
// Control/result bundle for freq_meter: measurement input, requests and published result.
interface freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic             start;
    logic             continuous;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output sig_in, start, continuous,
        input  busy, valid, count, ovf
    );

    modport slave (
        input  sig_in, start, continuous,
        output busy, valid, count, ovf
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clk
// cycles and publishes the saturating count with a one-cycle valid strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    freq_meter_if.slave bus
);
    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {IDLE, GATE} state_t;
    state_t state, state_nxt;

    logic             s1, s2, s3;
    logic             edge_pulse;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
    logic             sat, sat_nxt;
    logic             in_gate, gate_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_gate   = 1'b0;
        gate_end  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start || bus.continuous) state_nxt = GATE;
            end
            GATE: begin
                in_gate  = 1'b1;
                gate_end = (gate_cnt == GATE_LAST);
                if (gate_end && !bus.continuous) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = in_gate;

    // Saturating increment; the final cycle's edge is folded into the published result.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        sat_nxt      = sat;
        if (edge_pulse) begin
            if (edge_cnt == CNT_MAX) sat_nxt = 1'b1;
            else                     edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            sat       <= 1'b0;
            bus.valid <= 1'b0;
            bus.count <= '0;
            bus.ovf   <= 1'b0;
        end else begin
            bus.valid <= gate_end;
            if (!in_gate || gate_end) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                edge_cnt <= edge_cnt_nxt;
                sat      <= sat_nxt;
            end
            if (gate_end) begin
                bus.count <= edge_cnt_nxt;
                bus.ovf   <= sat_nxt;
            end
        end
    end
endmodule
